ram_arbiter: RTL and testbench

- Shares the single-port 64 KB RAM (8-bit data, 16-bit address, one-cycle read latency) between two requesters:
  - port A: 6502 CPU.
  - port B: DMA/video fetch engine.
- Grants at most one access per clock.
  - Port A has priority.
  - Port B is protected by a starvation counter.
- Routes the RAM read data back to the port that issued the read, with a valid strobe.
- Sits between the requesters and the RAM block's addr/dbw/we/dbr pins.

---
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-port arbiter for a single-port 64 KB RAM (8-bit data,
//             one-cycle read latency). Port A (CPU) has priority; port B
//             (DMA/video) gets forced priority after MAX_WAIT denied cycles.
//             Read data is routed back to the issuing port with a strobe.
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Port A (CPU)
  input  logic        a_req_i,
  input  logic [15:0] a_addr_i,
  input  logic        a_we_i,
  input  logic [7:0]  a_wdata_i,
  output logic        a_ack_o,
  output logic        a_rvalid_o,
  output logic [7:0]  a_rdata_o,
  // Port B (DMA / video fetch)
  input  logic        b_req_i,
  input  logic [15:0] b_addr_i,
  input  logic        b_we_i,
  input  logic [7:0]  b_wdata_i,
  output logic        b_ack_o,
  output logic        b_rvalid_o,
  output logic [7:0]  b_rdata_o,
  // RAM side
  output logic [15:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_dbw_o,
  input  logic [7:0]  ram_dbr_i
);

  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] C_CNT_SAT  = '1;

  // Which port (if any) owns the RAM output in the current cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       addr_q;
  owner_e            rd_owner_q, rd_owner_d;
  logic [7:0]        a_hold_q, b_hold_q;

  logic force_b;
  logic grant_a;
  logic grant_b;

  // Grant decision; both grants are suppressed while reset is asserted
  always_comb begin
    force_b = (wait_cnt_q >= C_MAX_WAIT);
    grant_b = rst_ni & b_req_i & (~a_req_i | force_b);
    grant_a = rst_ni & a_req_i & ~grant_b;
  end

  assign a_ack_o = grant_a;
  assign b_ack_o = grant_b;

  // RAM drive mux; idle cycles keep the last address so RAM output is stable
  always_comb begin
    ram_addr_o = addr_q;
    ram_we_o   = 1'b0;
    ram_dbw_o  = 8'h00;
    if (grant_a) begin
      ram_addr_o = a_addr_i;
      ram_we_o   = a_we_i;
      ram_dbw_o  = a_wdata_i;
    end else if (grant_b) begin
      ram_addr_o = b_addr_i;
      ram_we_o   = b_we_i;
      ram_dbw_o  = b_wdata_i;
    end
  end

  // Next-state for starvation counter and read-return owner
  always_comb begin
    wait_cnt_d = '0;
    if (b_req_i && !grant_b) begin
      wait_cnt_d = (wait_cnt_q == C_CNT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    rd_owner_d = OWN_NONE;
    if (grant_a && !a_we_i) begin
      rd_owner_d = OWN_A;
    end else if (grant_b && !b_we_i) begin
      rd_owner_d = OWN_B;
    end
  end

  // Arbitration state, read owner and per-port read-data hold registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      addr_q     <= 16'h0000;
      rd_owner_q <= OWN_NONE;
      a_hold_q   <= 8'h00;
      b_hold_q   <= 8'h00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
      if (grant_a || grant_b) begin
        addr_q <= ram_addr_o;
      end
      if (rd_owner_q == OWN_A) begin
        a_hold_q <= ram_dbr_i;
      end
      if (rd_owner_q == OWN_B) begin
        b_hold_q <= ram_dbr_i;
      end
    end
  end

  // Read return: live RAM data during the valid cycle, held value otherwise
  assign a_rvalid_o = (rd_owner_q == OWN_A);
  assign b_rvalid_o = (rd_owner_q == OWN_B);
  assign a_rdata_o  = a_rvalid_o ? ram_dbr_i : a_hold_q;
  assign b_rdata_o  = b_rvalid_o ? ram_dbr_i : b_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed self-checking bench for ram_arbiter with a behavioural
//             single-port RAM (one-cycle read latency) attached.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dbw;
  logic [7:0]  ram_dbr;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.MAX_WAIT(3), .WAIT_W(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_req_i   (a_req),
    .a_addr_i  (a_addr),
    .a_we_i    (a_we),
    .a_wdata_i (a_wdata),
    .a_ack_o   (a_ack),
    .a_rvalid_o(a_rvalid),
    .a_rdata_o (a_rdata),
    .b_req_i   (b_req),
    .b_addr_i  (b_addr),
    .b_we_i    (b_we),
    .b_wdata_i (b_wdata),
    .b_ack_o   (b_ack),
    .b_rvalid_o(b_rvalid),
    .b_rdata_o (b_rdata),
    .ram_addr_o(ram_addr),
    .ram_we_o  (ram_we),
    .ram_dbw_o (ram_dbw),
    .ram_dbr_i (ram_dbr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, read-before-write, one-cycle read latency
  always @(posedge clk) begin
    ram_dbr <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_dbw;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sampling point)
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 16'h0; a_wdata = 8'h0;
    b_req = 0; b_we = 0; b_addr = 16'h0; b_wdata = 8'h0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h11;
    mem[16'h0020] = 8'h22;
    for (int i = 0; i < 8; i++) mem[16'h0300 + i] = 8'h30 + 8'(i);

    idle_inputs();
    rst_n = 0;

    // ---- During reset: requests must not be acknowledged or write RAM
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 8'hEE;
    step();
    sample();
    check_eq("rst_a_ack", a_ack, 0);
    check_eq("rst_ram_we", ram_we, 0);

    // ---- Release reset, idle
    step();
    idle_inputs();
    rst_n = 1;
    sample();
    check_eq("idle_a_ack", a_ack, 0);
    check_eq("idle_b_ack", b_ack, 0);
    check_eq("idle_ram_we", ram_we, 0);
    check_eq("idle_ram_addr", ram_addr, 16'h0000);
    check_eq("idle_a_rvalid", a_rvalid, 0);
    check_eq("idle_b_rvalid", b_rvalid, 0);
    check_eq("idle_a_rdata", a_rdata, 8'h00);
    check_eq("idle_b_rdata", b_rdata, 8'h00);
    check_eq("rst_mem_kept", mem[16'h0010], 8'h11);

    // ---- A writes 5A to 1234, then reads it back
    step();
    a_req = 1; a_we = 1; a_addr = 16'h1234; a_wdata = 8'h5A;
    sample();
    check_eq("wr_a_ack", a_ack, 1);
    check_eq("wr_ram_we", ram_we, 1);
    check_eq("wr_ram_addr", ram_addr, 16'h1234);
    check_eq("wr_ram_dbw", ram_dbw, 8'h5A);
    step();
    a_we = 0;
    sample();
    check_eq("rd_a_ack", a_ack, 1);
    check_eq("rd_ram_we", ram_we, 0);
    check_eq("wr_no_rvalid", a_rvalid, 0);
    step();
    a_req = 0;
    sample();
    check_eq("rd_a_rvalid", a_rvalid, 1);
    check_eq("rd_a_rdata", a_rdata, 8'h5A);
    check_eq("rd_b_rvalid", b_rvalid, 0);
    step();
    sample();
    check_eq("rd_a_rvalid_drop", a_rvalid, 0);
    check_eq("rd_a_rdata_hold", a_rdata, 8'h5A);
    check_eq("idle_addr_held", ram_addr, 16'h1234);

    // ---- Contention: pattern A,A,A,B repeating, wait_cnt 0,1,2,3
    step();
    a_req = 1; a_addr = 16'h0100;
    b_req = 1; b_addr = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      sample();
      check_eq($sformatf("cont_a_ack[%0d]", i), a_ack, (i % 4 == 3) ? 0 : 1);
      check_eq($sformatf("cont_b_ack[%0d]", i), b_ack, (i % 4 == 3) ? 1 : 0);
      check_eq($sformatf("cont_wait[%0d]", i), dut.wait_cnt_q, i % 4);
      step();
    end
    idle_inputs();
    step();
    step();

    // ---- Interleaved reads: A@0010 then B@0020
    a_req = 1; a_addr = 16'h0010;
    sample();
    check_eq("il_a_ack", a_ack, 1);
    step();
    a_req = 0;
    b_req = 1; b_addr = 16'h0020;
    sample();
    check_eq("il_b_ack", b_ack, 1);
    check_eq("il_a_rvalid", a_rvalid, 1);
    check_eq("il_a_rdata", a_rdata, 8'h11);
    step();
    b_req = 0;
    sample();
    check_eq("il_b_rvalid", b_rvalid, 1);
    check_eq("il_b_rdata", b_rdata, 8'h22);
    check_eq("il_a_rvalid_off", a_rvalid, 0);
    step();
    sample();
    check_eq("il_a_hold", a_rdata, 8'h11);
    check_eq("il_b_hold", b_rdata, 8'h22);
    check_eq("il_b_rvalid_off", b_rvalid, 0);

    // ---- B alone, back-to-back reads 0300..0307
    for (int i = 0; i < 8; i++) begin
      step();
      b_req = 1; b_addr = 16'h0300 + 16'(i);
      sample();
      check_eq($sformatf("bb_ack[%0d]", i), b_ack, 1);
      check_eq($sformatf("bb_wait[%0d]", i), dut.wait_cnt_q, 0);
      check_eq($sformatf("bb_rvalid[%0d]", i), b_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) check_eq($sformatf("bb_rdata[%0d]", i), b_rdata, 8'h30 + 8'(i - 1));
    end
    step();
    b_req = 0;
    sample();
    check_eq("bb_last_rvalid", b_rvalid, 1);
    check_eq("bb_last_rdata", b_rdata, 8'h37);
    step();
    sample();
    check_eq("bb_end_rvalid", b_rvalid, 0);

    // ---- Reset in the cycle after a granted read
    step();
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    sample();
    check_eq("mr_a_ack", a_ack, 1);
    step();
    rst_n = 0;
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 8'hFF;
    sample();
    check_eq("mr_a_rvalid", a_rvalid, 0);
    check_eq("mr_a_rdata", a_rdata, 8'h00);
    check_eq("mr_b_rdata", b_rdata, 8'h00);
    check_eq("mr_ram_we", ram_we, 0);
    check_eq("mr_a_ack", a_ack, 0);
    step();
    sample();
    check_eq("mr_a_rvalid2", a_rvalid, 0);
    check_eq("mr_mem_kept", mem[16'h0010], 8'h11);

    // ---- First cycle after reset arbitrates normally
    step();
    rst_n = 1;
    a_we = 0;
    sample();
    check_eq("pr_a_ack", a_ack, 1);
    step();
    a_req = 0;
    sample();
    check_eq("pr_a_rvalid", a_rvalid, 1);
    check_eq("pr_a_rdata", a_rdata, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
